// File: rtl/usb_buf_pkg.sv
// Shared types and constants for the endpoint buffer controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package usb_buf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_RECV,
    RX_READY,
    TX_FILL,
    TX_START,
    TX_SEND
  } buf_state_t;

  localparam int BUF_DEPTH_C = 64;
  localparam int OCC_W       = 7;

endpackage

// File: rtl/buffer_ctrl.sv
// Sequencer that arbitrates the shared endpoint buffer between USB RX, USB TX and AHB.
// Latency: every strobe/pulse is registered, 1 cycle after its cause; tx_packet_start 2 cycles after commit.
// Backpressure: none; RX packets arriving while the buffer is busy are refused with rx_nak.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   rx_packet_start/byte_valid/   USB RX events (pulses)
//     packet_end/packet_err
//   ahb_read_done, ahb_tx_write,  AHB slave events; ahb_tx_len sampled on ahb_tx_commit
//     ahb_tx_commit, ahb_tx_len,
//     ahb_clear_req
//   tx_byte_req, tx_packet_done   USB TX events (pulses)
//   buffer_occupancy              current fill level from data_buffer
//   store_rx_packet_data,         buffer strobes
//     get_tx_packet_data, clear
//   buffer_reserved,              status levels
//     rx_data_ready, ctrl_err
//   tx_packet_start, rx_nak       one-cycle notifications
module buffer_ctrl
  import usb_buf_pkg::*;
#(
  parameter int BUF_DEPTH = BUF_DEPTH_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_packet_start,
  input  logic             rx_byte_valid,
  input  logic             rx_packet_end,
  input  logic             rx_packet_err,
  input  logic             ahb_read_done,
  input  logic             ahb_tx_write,
  input  logic             ahb_tx_commit,
  input  logic [OCC_W-1:0] ahb_tx_len,
  input  logic             ahb_clear_req,
  input  logic             tx_byte_req,
  input  logic             tx_packet_done,
  input  logic [OCC_W-1:0] buffer_occupancy,
  output logic             store_rx_packet_data,
  output logic             get_tx_packet_data,
  output logic             clear,
  output logic             buffer_reserved,
  output logic             tx_packet_start,
  output logic             rx_data_ready,
  output logic             rx_nak,
  output logic             ctrl_err
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  buf_state_t       state_q, state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             err_d;
  logic             store_d, get_d, clear_d, nak_d;
  logic             tx_start_d, reserved_d, ready_d;
  logic             rx_full;
  logic             commit_ok;

  assign rx_full   = (int'(rx_cnt_q) >= BUF_DEPTH);
  // A commit is only honoured if the announced length matches what AHB actually wrote.
  assign commit_ok = (ahb_tx_len == buffer_occupancy) && (ahb_tx_len != '0) &&
                     (int'(ahb_tx_len) <= BUF_DEPTH);

  always_comb begin
    state_d  = state_q;
    rx_cnt_d = rx_cnt_q;
    tx_cnt_d = tx_cnt_q;
    err_d    = ctrl_err;
    store_d  = 1'b0;
    get_d    = 1'b0;
    clear_d  = 1'b0;
    nak_d    = 1'b0;

    if (ahb_clear_req) begin
      // Flush overrides every other event in the same cycle.
      state_d  = IDLE;
      rx_cnt_d = '0;
      tx_cnt_d = '0;
      err_d    = 1'b0;
      clear_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // RX has priority: a simultaneous AHB write is simply not started.
          if (rx_packet_start) begin
            state_d  = RX_RECV;
            rx_cnt_d = '0;
          end else if (ahb_tx_write) begin
            state_d = TX_FILL;
          end
        end
        RX_RECV: begin
          if (rx_packet_err) begin
            clear_d = 1'b1;
            state_d = IDLE;
          end else begin
            if (rx_byte_valid) begin
              if (rx_full) begin
                err_d = 1'b1;
              end else begin
                store_d  = 1'b1;
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
              end
            end
            // An empty packet leaves nothing for AHB, so go straight back to IDLE.
            if (rx_packet_end) begin
              state_d = (rx_cnt_d != '0) ? RX_READY : IDLE;
            end
          end
        end
        RX_READY: begin
          nak_d = rx_packet_start;
          if (ahb_read_done || (buffer_occupancy == '0)) begin
            state_d = IDLE;
          end
        end
        TX_FILL: begin
          nak_d = rx_packet_start;
          if (ahb_tx_commit) begin
            if (commit_ok) begin
              tx_cnt_d = CNT_W'(ahb_tx_len);
              state_d  = TX_START;
            end else begin
              clear_d = 1'b1;
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        TX_START: begin
          nak_d   = rx_packet_start;
          state_d = TX_SEND;
        end
        TX_SEND: begin
          nak_d = rx_packet_start;
          if (tx_byte_req) begin
            if (tx_cnt_q != '0) begin
              get_d    = 1'b1;
              tx_cnt_d = tx_cnt_q - CNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end
          // Ending with bytes left means the buffer holds stale data: flush it.
          if (tx_packet_done) begin
            state_d = IDLE;
            if (tx_cnt_d != '0) begin
              clear_d = 1'b1;
              err_d   = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    tx_start_d = (state_q == TX_START) && !ahb_clear_req;
    reserved_d = (state_d == RX_READY) || (state_d == TX_FILL);
    ready_d    = (state_d == RX_READY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q              <= IDLE;
      rx_cnt_q             <= '0;
      tx_cnt_q             <= '0;
      ctrl_err             <= 1'b0;
      store_rx_packet_data <= 1'b0;
      get_tx_packet_data   <= 1'b0;
      clear                <= 1'b0;
      buffer_reserved      <= 1'b0;
      tx_packet_start      <= 1'b0;
      rx_data_ready        <= 1'b0;
      rx_nak               <= 1'b0;
    end else begin
      state_q              <= state_d;
      rx_cnt_q             <= rx_cnt_d;
      tx_cnt_q             <= tx_cnt_d;
      ctrl_err             <= err_d;
      store_rx_packet_data <= store_d;
      get_tx_packet_data   <= get_d;
      clear                <= clear_d;
      buffer_reserved      <= reserved_d;
      tx_packet_start      <= tx_start_d;
      rx_data_ready        <= ready_d;
      rx_nak               <= nak_d;
    end
  end

endmodule

// File: doc/buffer_ctrl.md
# buffer_ctrl

Sequencing controller for the shared 64-byte endpoint data buffer. It decides whether USB RX, USB TX or the AHB-Lite slave owns the buffer, turns byte-level handshakes into the buffer's strobes (`store_rx_packet_data`, `get_tx_packet_data`, `clear`, `buffer_reserved`), and tracks byte counts against `buffer_occupancy`. It sits between the USB RX/TX protocol FSMs, the AHB-Lite slave register file and `data_buffer`.

## Interface

- `BUF_DEPTH`, default 64: buffer capacity in bytes; sets the width of the count registers.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx_packet_start` in 1: USB RX has decoded the start of a DATA packet (pulse).
- `rx_byte_valid` in 1: USB RX has one byte available (pulse).
- `rx_packet_end` in 1: valid EOP, CRC good (pulse).
- `rx_packet_err` in 1: CRC or bit-stuff error (pulse).
- `ahb_read_done` in 1: AHB host has finished reading RX data (pulse).
- `ahb_tx_write` in 1: AHB is writing TX data into the buffer (mirrors `store_tx_data`).
- `ahb_tx_commit` in 1: AHB has written the TX length register (pulse).
- `ahb_tx_len` in 7: bytes to send; sampled on `ahb_tx_commit`.
- `ahb_clear_req` in 1: AHB flush request (pulse).
- `tx_byte_req` in 1: USB TX wants the next byte (pulse).
- `tx_packet_done` in 1: USB TX has sent EOP (pulse).
- `buffer_occupancy` in 7: current buffer fill, from `data_buffer`.
- `store_rx_packet_data` out 1: strobe that writes one RX byte into the buffer.
- `get_tx_packet_data` out 1: strobe that pops one byte to USB TX.
- `clear` out 1: one-cycle buffer flush.
- `buffer_reserved` out 1: high while the AHB side owns the buffer.
- `tx_packet_start` out 1: one-cycle pulse that starts USB TX.
- `rx_data_ready` out 1: level; a received packet is waiting for AHB.
- `rx_nak` out 1: pulse; an RX packet was refused because the buffer is not free.
- `ctrl_err` out 1: sticky protocol-error flag.

## Operation

- FSM states: IDLE, RX_RECV, RX_READY, TX_FILL, TX_START, TX_SEND.
- **IDLE**
  - `rx_packet_start` → RX_RECV.
  - `ahb_tx_write` → TX_FILL.
  - If both arrive in the same cycle, RX wins and `rx_nak` is not asserted.
- **RX_RECV**
  - Each `rx_byte_valid` produces one `store_rx_packet_data` pulse and increments `rx_cnt`.
  - If `rx_cnt == BUF_DEPTH`, the byte is dropped and `ctrl_err` is set.
  - `rx_packet_end` with `rx_cnt > 0` → RX_READY.
  - `rx_packet_end` with `rx_cnt == 0` → IDLE, no clear.
  - `rx_packet_err` → `clear` pulse, → IDLE, `ctrl_err` is not set.
- **RX_READY**
  - `rx_data_ready` = 1 and `buffer_reserved` = 1.
  - `ahb_read_done`, or `buffer_occupancy == 0`, → IDLE.
  - `rx_packet_start` in this state → `rx_nak` pulse, state unchanged.
- **TX_FILL**
  - `buffer_reserved` = 1.
  - `ahb_tx_commit` with `ahb_tx_len == buffer_occupancy` and `1 ≤ ahb_tx_len ≤ BUF_DEPTH`: load `tx_cnt = ahb_tx_len`, → TX_START.
  - Any other commit: `clear` pulse, set `ctrl_err`, → IDLE.
  - `rx_packet_start` in this state → `rx_nak` pulse.
- **TX_START**: one cycle; `tx_packet_start` = 1; → TX_SEND.
- **TX_SEND**
  - `tx_byte_req` with `tx_cnt > 0` → `get_tx_packet_data` pulse, `tx_cnt` − 1.
  - `tx_byte_req` with `tx_cnt == 0` → no pop, set `ctrl_err`.
  - `tx_packet_done` → IDLE. If `tx_cnt != 0` at that point, also pulse `clear` and set `ctrl_err`.
  - `rx_packet_start` in this state → `rx_nak` pulse.
- **AHB flush**: `ahb_clear_req` in any state pulses `clear`, resets both counters, clears `ctrl_err` and → IDLE. It takes priority over every other input in the same cycle.
- `rx_cnt` and `tx_cnt` are 7-bit unsigned. They saturate at 0 and at `BUF_DEPTH` and never wrap.

## Timing

- All outputs are registered. Every strobe and pulse is exactly one cycle wide.
- `store_rx_packet_data` and `get_tx_packet_data` assert the cycle after their request pulse (latency 1).
- `tx_packet_start` asserts exactly 2 cycles after an accepted `ahb_tx_commit`.
- `clear` asserts the cycle after its cause.
- `buffer_reserved` and `rx_data_ready` are decoded from the registered state, so they change one cycle after the state-changing input.
- `rst` asynchronously forces state IDLE and both counters to 0; every output reads 0 while `rst` is high. Deassertion is synchronous to `clk`.
- A `rst` pulse during TX_SEND or RX_RECV does not itself pulse `clear`. `data_buffer` is reset by the same system reset.
- Back-to-back request pulses, one per cycle, are supported. Each one produces exactly one strobe.

## Structure

- Package `usb_buf_pkg`:
  - `buf_state_t`: enum of the six FSM states.
  - `BUF_DEPTH_C = 64`.
  - `OCC_W = 7`.
- Single module with no sub-modules. The two byte counters are inline registers.

## Test plan

1. Reset, `rx_packet_start`, 4 × `rx_byte_valid`, `rx_packet_end` → 4 `store_rx_packet_data` pulses, `rx_data_ready` = 1, `buffer_reserved` = 1. Then `ahb_read_done` → IDLE, both outputs 0.
2. 2 × `ahb_tx_write`, `buffer_occupancy` = 2, `ahb_tx_commit` with `ahb_tx_len` = 2 → `tx_packet_start` 2 cycles later. Then 2 × `tx_byte_req` → 2 `get_tx_packet_data` pulses. Then `tx_packet_done` → IDLE, `ctrl_err` = 0.
3. 65 × `rx_byte_valid` in one packet → 64 stores, `ctrl_err` = 1. Then `ahb_clear_req` → `clear` pulse, `ctrl_err` = 0.
4. `ahb_tx_commit` with `ahb_tx_len` = 5 while `buffer_occupancy` = 3 → `clear` pulse, `ctrl_err` = 1, state IDLE, no `tx_packet_start`.
5. `rx_packet_start` during RX_READY → `rx_nak` pulse, buffer untouched. `rx_packet_err` mid-RX → `clear` pulse, IDLE.
6. Assert `rst` mid-TX_SEND with `tx_cnt` = 3 → all outputs 0 immediately. After release, `tx_byte_req` produces no `get_tx_packet_data`.
